// File: rtl/if_fetch_if.sv
// Byte-wide read port between the fetch stage and the shared memory arbiter.
interface if_fetch_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_data_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_data_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_data_i
  );
endinterface

// File: rtl/if_fetch.sv
// RV32I instruction fetch: assembles each 32-bit instruction from four byte reads,
// presents it to if_id with a valid flag, holds it under stall, and accepts redirects.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               jump_i,
  input  logic [31:0]        jump_addr_i,
  if_fetch_if.master         mem,
  output logic [31:0]        pc_o,
  output logic [31:0]        inst_o,
  output logic               flag_o
);

  logic [31:0] pc_q, pc_d;
  logic [2:0]  icnt_q, icnt_d;
  logic [2:0]  rcnt_q, rcnt_d;
  logic        pend_q, pend_d;
  logic [1:0]  slot_q, slot_d;
  // Only bytes 0..2 are buffered; byte 3 goes straight into inst_o on completion.
  logic [7:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_q, inst_d;
  logic        flag_q, flag_d;
  logic        req;

  assign req            = !rst && !jump_i && !flag_q && (icnt_q < 3'd4);
  assign mem.mem_req_o  = req;
  assign mem.mem_addr_o = rst ? 32'h0 : pc_q + {29'd0, icnt_q};

  assign pc_o   = pc_out_q;
  assign inst_o = inst_q;
  assign flag_o = flag_q;

  always_comb begin
    pc_d     = pc_q;
    icnt_d   = icnt_q;
    rcnt_d   = rcnt_q;
    pend_d   = pend_q;
    slot_d   = slot_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    b2_d     = b2_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    flag_d   = flag_q;

    if (jump_i) begin
      // Redirect wins over stall and over a completing fetch; in-flight byte is dropped.
      pc_d   = jump_addr_i;
      icnt_d = 3'd0;
      rcnt_d = 3'd0;
      pend_d = 1'b0;
      flag_d = 1'b0;
    end else if (flag_q) begin
      if (!stall_i) begin
        flag_d = 1'b0;
        pc_d   = pc_q + 32'd4;
        icnt_d = 3'd0;
        rcnt_d = 3'd0;
        pend_d = 1'b0;
      end
    end else begin
      pend_d = 1'b0;
      if (req && mem.mem_gnt_i) begin
        icnt_d = icnt_q + 3'd1;
        pend_d = 1'b1;
        slot_d = icnt_q[1:0];
      end
      if (pend_q) begin
        rcnt_d = rcnt_q + 3'd1;
        case (slot_q)
          2'd0:    b0_d = mem.mem_data_i;
          2'd1:    b1_d = mem.mem_data_i;
          2'd2:    b2_d = mem.mem_data_i;
          default: ;
        endcase
        if (rcnt_q == 3'd3) begin
          flag_d   = 1'b1;
          pc_out_d = pc_q;
          inst_d   = {mem.mem_data_i, b2_q, b1_q, b0_q};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      icnt_q   <= 3'd0;
      rcnt_q   <= 3'd0;
      pend_q   <= 1'b0;
      slot_q   <= 2'd0;
      b0_q     <= 8'h00;
      b1_q     <= 8'h00;
      b2_q     <= 8'h00;
      pc_out_q <= 32'h0;
      inst_q   <= 32'h0;
      flag_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      icnt_q   <= icnt_d;
      rcnt_q   <= rcnt_d;
      pend_q   <= pend_d;
      slot_q   <= slot_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      b2_q     <= b2_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      flag_q   <= flag_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte-memory responder, per-cycle reference model, literal checks.
module tb_if_fetch;
  logic        clk;
  logic        rst;
  logic        stall;
  logic        jump;
  logic [31:0] jump_addr;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        flag_o;

  if_fetch_if mem_bus ();

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall),
    .jump_i     (jump),
    .jump_addr_i(jump_addr),
    .mem        (mem_bus),
    .pc_o       (pc_o),
    .inst_o     (inst_o),
    .flag_o     (flag_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] v;
    case (a)
      32'd0:   v = 8'h13;
      32'd1:   v = 8'h05;
      32'd2:   v = 8'h50;
      32'd3:   v = 8'h00;
      default: v = 8'(a[7:0] * 8'd37 + 8'd11) ^ a[15:8];
    endcase
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Memory responder: data for an accepted request is driven during the following cycle.
  logic        acc;
  logic [31:0] acc_addr;
  initial begin
    acc = 1'b0;
    acc_addr = 32'h0;
    mem_bus.mem_data_i = 8'h00;
    forever begin
      @(negedge clk);
      acc = mem_bus.mem_req_o && mem_bus.mem_gnt_i;
      acc_addr = mem_bus.mem_addr_o;
      @(posedge clk);
      #1;
      mem_bus.mem_data_i = acc ? mem_byte(acc_addr) : 8'($urandom);
    end
  end

  // Reference model: fetch PC plus counts of granted and delivered bytes.
  initial begin
    logic [31:0] m_pc;
    int          m_issued;
    int          m_rcvd;
    logic        m_pend;
    logic        m_flag;
    logic        exp_req;
    m_pc = 32'h0; m_issued = 0; m_rcvd = 0; m_pend = 1'b0; m_flag = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("mon_rst_req", 32'(mem_bus.mem_req_o), 32'h0);
        chk("mon_rst_addr", mem_bus.mem_addr_o, 32'h0);
        chk("mon_rst_flag", 32'(flag_o), 32'h0);
        chk("mon_rst_pc", pc_o, 32'h0);
        chk("mon_rst_inst", inst_o, 32'h0);
        m_pc = 32'h0; m_issued = 0; m_rcvd = 0; m_pend = 1'b0; m_flag = 1'b0;
      end else begin
        exp_req = !jump && !m_flag && (m_issued < 4);
        chk("mon_req", 32'(mem_bus.mem_req_o), 32'(exp_req));
        if (exp_req) chk("mon_addr", mem_bus.mem_addr_o, m_pc + 32'(m_issued));
        chk("mon_flag", 32'(flag_o), 32'(m_flag));
        if (m_flag) begin
          chk("mon_pc", pc_o, m_pc);
          chk("mon_inst", inst_o, mem_word(m_pc));
        end
        if (jump) begin
          m_pc = jump_addr; m_issued = 0; m_rcvd = 0; m_pend = 1'b0; m_flag = 1'b0;
        end else if (m_flag) begin
          if (!stall) begin
            m_flag = 1'b0; m_pc = m_pc + 32'd4; m_issued = 0; m_rcvd = 0;
          end
        end else begin
          if (m_pend) begin
            m_rcvd++;
            if (m_rcvd == 4) m_flag = 1'b1;
          end
          m_pend = exp_req && mem_bus.mem_gnt_i;
          if (m_pend) m_issued++;
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    next();
    @(negedge clk);
  endtask

  task automatic exp_req(input string name, input logic r, input logic [31:0] a);
    chk({name, "_req"}, 32'(mem_bus.mem_req_o), 32'(r));
    if (r) chk({name, "_addr"}, mem_bus.mem_addr_o, a);
  endtask

  task automatic exp_out(input string name, input logic f, input logic [31:0] pc,
                         input logic [31:0] inst);
    chk({name, "_flag"}, 32'(flag_o), 32'(f));
    if (f) begin
      chk({name, "_pc"}, pc_o, pc);
      chk({name, "_inst"}, inst_o, inst);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jump = 1'b0; jump_addr = 32'h0;
    mem_bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    exp_req("reset", 1'b0, 32'h0);
    exp_out("reset", 1'b0, 32'h0, 32'h0);

    // Reset then fetch
    next(); rst = 1'b0; @(negedge clk);
    exp_req("f0_b0", 1'b1, 32'h0);
    for (int i = 1; i < 4; i++) begin
      step(); exp_req("f0_bn", 1'b1, 32'(i));
    end
    step(); exp_req("f0_gap", 1'b0, 32'h0); exp_out("f0_gap", 1'b0, 32'h0, 32'h0);
    step(); exp_out("f0_done", 1'b1, 32'h0, 32'h0050_0513); exp_req("f0_done", 1'b0, 32'h0);
    step(); exp_out("f0_next", 1'b0, 32'h0, 32'h0); exp_req("f0_next", 1'b1, 32'h4);

    // Grant denial on byte 2
    step(); exp_req("gd_b1", 1'b1, 32'h5);
    next(); mem_bus.mem_gnt_i = 1'b0; @(negedge clk); exp_req("gd_hold0", 1'b1, 32'h6);
    step(); exp_req("gd_hold1", 1'b1, 32'h6);
    next(); mem_bus.mem_gnt_i = 1'b1; @(negedge clk); exp_req("gd_hold2", 1'b1, 32'h6);
    step(); exp_req("gd_b3", 1'b1, 32'h7);
    step(); exp_out("gd_late", 1'b0, 32'h0, 32'h0);

    // Stall for 4 cycles while presenting
    next(); stall = 1'b1; @(negedge clk);
    exp_out("gd_done", 1'b1, 32'h4, 32'h0EE9_C49F); exp_req("st0", 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(); exp_out("st_hold", 1'b1, 32'h4, 32'h0EE9_C49F); exp_req("st_hold", 1'b0, 32'h0);
    end
    next(); stall = 1'b0; @(negedge clk); exp_out("st_rel", 1'b1, 32'h4, 32'h0EE9_C49F);
    step(); exp_out("st_after", 1'b0, 32'h0, 32'h0); exp_req("st_after", 1'b1, 32'h8);

    // Redirect in the byte-2 issue cycle
    step(); exp_req("jm_b1", 1'b1, 32'h9);
    next(); jump = 1'b1; jump_addr = 32'h100; @(negedge clk); exp_req("jm_cyc", 1'b0, 32'h0);
    next(); jump = 1'b0; @(negedge clk); exp_req("jm_t0", 1'b1, 32'h100);
    for (int i = 1; i < 4; i++) begin
      step(); exp_req("jm_tn", 1'b1, 32'h100 + 32'(i));
    end
    step(); exp_out("jm_gap", 1'b0, 32'h0, 32'h0);

    // Redirect against a stalled output
    next(); stall = 1'b1; @(negedge clk); exp_out("jm_done", 1'b1, 32'h100, 32'h7B54_310A);
    next(); jump = 1'b1; jump_addr = 32'h40; @(negedge clk);
    exp_out("js_stalled", 1'b1, 32'h100, 32'h7B54_310A);
    next(); jump = 1'b0; stall = 1'b0; @(negedge clk);
    exp_out("js_drop", 1'b0, 32'h0, 32'h0); exp_req("js_t0", 1'b1, 32'h40);
    step(); exp_req("js_t1", 1'b1, 32'h41);
    step(); exp_req("js_t2", 1'b1, 32'h42);
    step(); exp_req("js_t3", 1'b1, 32'h43);

    // Asynchronous reset between edges, two bytes received
    #2 rst = 1'b1;
    #1;
    exp_req("ar_now", 1'b0, 32'h0);
    chk("ar_now_addr", mem_bus.mem_addr_o, 32'h0);
    chk("ar_now_flag", 32'(flag_o), 32'h0);
    chk("ar_now_pc", pc_o, 32'h0);
    chk("ar_now_inst", inst_o, 32'h0);
    @(negedge clk);
    next(); rst = 1'b0; @(negedge clk); exp_req("ar_b0", 1'b1, 32'h0);
    for (int i = 1; i < 4; i++) begin
      step(); exp_req("ar_bn", 1'b1, 32'(i));
    end
    step(); exp_out("ar_gap", 1'b0, 32'h0, 32'h0);
    step(); exp_out("ar_done", 1'b1, 32'h0, 32'h0050_0513);
    step(); exp_req("ar_next", 1'b1, 32'h4);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
